frogger_sprite_renderer: RTL
============================

Name: frogger_sprite_renderer

Overview:
- Parametrised VGA scan and sprite renderer for the Frogger game: N_CARS car sprites plus the frog, each TILE_SIZE square.
- Per-car enable and colour; fixed draw priority; positions double-buffered at frame boundaries.
- Two-stage pipeline with sync outputs aligned to colour outputs.
- Detects frog/car pixel overlap and reports one collision pulse per frame to game logic.

Parameters:
- TILE_SIZE, 32, sprite edge in pixels (1..64)
- N_CARS, 4, number of car sprites (1..8)
- COLOR_BITS, 3, bits per colour channel
- H_VISIBLE_AREA, 640, visible pixels per line
- V_VISIBLE_AREA, 480, visible lines per frame
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_FRONT_PORCH, 16, horizontal front porch
- H_SYNC_PULSE, 96, hsync width
- V_FRONT_PORCH, 10, vertical front porch
- V_SYNC_PULSE, 2, vsync width

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  synchronous reset, active-high
- i_Frog_X  in  10  frog left-corner X
- i_Frog_Y  in  10  frog top-corner Y
- i_Car_X  in  10*N_CARS  car i X in bits [10i+9:10i]
- i_Car_Y  in  10*N_CARS  car i Y, same packing
- i_Car_Enable  in  N_CARS  car i drawn and collidable when 1
- i_Car_Color  in  3*N_CARS  car i colour code {R,G,B}; each bit expands to all-ones or all-zeros on its channel
- o_VGA_HSync  out  1  active-low hsync
- o_VGA_VSync  out  1  active-low vsync
- o_VGA_Red  out  COLOR_BITS  red
- o_VGA_Grn  out  COLOR_BITS  green
- o_VGA_Blu  out  COLOR_BITS  blue
- o_Frame_Start  out  1  one-cycle pulse when counters are at (0,0)
- o_Collision  out  1  one-cycle pulse: overlap occurred in the previous visible frame
- o_Collision_Mask  out  N_CARS  cars that overlapped the frog; valid while o_Collision=1, held until next pulse

Behaviour:
- Reset values:
  - h/v counters 0.
  - o_VGA_HSync=1, o_VGA_VSync=1.
  - Colours 0.
  - o_Frame_Start=0, o_Collision=0, o_Collision_Mask=0.
  - Shadow positions/enables/colours 0; pipeline registers cleared.
  - Reset mid-frame restarts at (0,0) on the next cycle.
- Counters:
  - h increments 0..H_TOTAL-1 and wraps.
  - v increments when h wraps, 0..V_TOTAL-1, and wraps.
- Shadow registers:
  - All i_Frog_*/i_Car_* inputs are sampled only on the cycle with h=H_TOTAL-1, v=V_TOTAL-1.
  - Rendering and collision use shadow values only, so mid-frame input changes have no visible effect until the next frame.
- Pipeline:
  - Stage 1 registers the visible flag, raw sync levels, frog hit and the N_CARS car-hit vector for counter (h,v).
  - Stage 2 registers colours and sync outputs.
  - Every output reflects the counter value of 2 cycles earlier.
  - o_VGA_HSync low for h in [656,752) shifted by 2 cycles; vsync likewise for v in [490,492).
- Hit test:
  - Sprite hit when h>=X && h<X+TILE_SIZE && v>=Y && v<Y+TILE_SIZE.
  - Sums computed at 11 bits, so no wrap; sprites past the visible edge are clipped, never wrapped to column 0.
  - Disabled cars never hit.
- Colour priority:
  - Frog: all-ones on every channel.
  - Otherwise the lowest-index hitting car, with its colour code expanded.
  - Otherwise 0.
  - Outside the visible area all channels are forced to 0.
- o_Frame_Start: registered from counters=(0,0), 1-cycle latency, not pipeline-aligned.
- Collision:
  - Sticky accumulator OR-s (frog hit & car hit vector) over visible pixels.
  - On the first cycle of v=V_VISIBLE_AREA (h=0): if the accumulator is non-zero, o_Collision pulses 1 cycle and o_Collision_Mask loads the accumulator.
  - The accumulator then clears.
  - An overlap on the final visible pixel is still counted; that pixel's hit is OR-ed before the clear.

Test Plan:
- Reset held 3 cycles, then released → HSync/VSync=1 and colours 0 during reset; o_Frame_Start pulses at cycle 1 after release, then every 420000 cycles.
- Free run one line → HSync low for exactly 96 cycles, first low output 658 cycles after h=0; VSync low for 2 lines (1600 cycles).
- Frog (100,50), no cars, applied before frame end → pixel (100,50) all-ones, (132,50) 0, (99,50) 0 at 2-cycle latency.
- Car0 code 3'b101 and car1 code 3'b010, both at (200,100) enabled, frog elsewhere → pixel (210,110) R=111, G=000, B=111; frog moved onto it → all-ones; car0 disabled → G only.
- Frog (300,300) and car2 (310,290) enabled → o_Collision pulses once at v=480, h=0 (+1 cycle) with mask 4'b0100; car2 moved away before next frame → no pulse.
- Car0 X changed to 630 mid-frame → no change until next frame; then pixels 630..639 coloured and column 0 background (no wrap).

Source files
------------

// File: rtl/frogger_sprite_renderer_if.sv
// Game-logic <-> renderer bundle: frame-latched sprite inputs in, VGA timing,
// colour and per-frame collision report out.
interface frogger_sprite_renderer_if #(
  parameter int N_CARS     = 4,
  parameter int COLOR_BITS = 3
);
  logic [9:0]            i_Frog_X;
  logic [9:0]            i_Frog_Y;
  logic [10*N_CARS-1:0]  i_Car_X;
  logic [10*N_CARS-1:0]  i_Car_Y;
  logic [N_CARS-1:0]     i_Car_Enable;
  logic [3*N_CARS-1:0]   i_Car_Color;
  logic                  o_VGA_HSync;
  logic                  o_VGA_VSync;
  logic [COLOR_BITS-1:0] o_VGA_Red;
  logic [COLOR_BITS-1:0] o_VGA_Grn;
  logic [COLOR_BITS-1:0] o_VGA_Blu;
  logic                  o_Frame_Start;
  logic                  o_Collision;
  logic [N_CARS-1:0]     o_Collision_Mask;

  modport master (
    output i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y, i_Car_Enable, i_Car_Color,
    input  o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu,
    input  o_Frame_Start, o_Collision, o_Collision_Mask
  );

  modport slave (
    input  i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y, i_Car_Enable, i_Car_Color,
    output o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu,
    output o_Frame_Start, o_Collision, o_Collision_Mask
  );
endinterface

// File: rtl/frogger_sprite_renderer.sv
// Frogger VGA scan generator and sprite renderer: frog plus N_CARS cars with
// frame-latched positions, a two-stage colour pipeline and a per-frame collision report.
module frogger_sprite_renderer #(
  parameter int TILE_SIZE      = 32,
  parameter int N_CARS         = 4,
  parameter int COLOR_BITS     = 3,
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int H_TOTAL        = 800,
  parameter int V_TOTAL        = 525,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  frogger_sprite_renderer_if.slave bus
);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE_AREA);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE_AREA);
  localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic [10:0] TILE     = 11'(TILE_SIZE);

  // 11-bit sums keep sprites near the right/bottom edge clipped instead of wrapping.
  function automatic logic sprite_hit(input logic [10:0] h, input logic [10:0] v,
                                      input logic [9:0] x, input logic [9:0] y);
    logic [10:0] x_w;
    logic [10:0] y_w;
    x_w = {1'b0, x};
    y_w = {1'b0, y};
    return (h >= x_w) && (h < x_w + TILE) && (v >= y_w) && (v < y_w + TILE);
  endfunction

  function automatic logic [COLOR_BITS-1:0] expand(input logic b);
    return {COLOR_BITS{b}};
  endfunction

  logic [10:0]           h_q, h_d, v_q, v_d;
  logic [9:0]            frog_x_q, frog_x_d, frog_y_q, frog_y_d;
  logic [10*N_CARS-1:0]  car_x_q, car_x_d, car_y_q, car_y_d;
  logic [N_CARS-1:0]     car_en_q, car_en_d;
  logic [3*N_CARS-1:0]   car_col_q, car_col_d;
  logic                  vis_p1_q, vis_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic                  frog_p1_q, frog_p1_d;
  logic [N_CARS-1:0]     car_p1_q, car_p1_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic [COLOR_BITS-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                  frame_start_q, frame_start_d, collision_q, collision_d;
  logic [N_CARS-1:0]     acc_q, acc_d, mask_q, mask_d;
  logic                  frame_end, visible, frog_hit;
  logic [N_CARS-1:0]     car_hit;

  // Stage 0: scan counters, frame-boundary shadow load, hit tests, collision accumulation
  always_comb begin
    frame_end = (h_q == H_LAST) && (v_q == V_LAST);
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
    end

    frog_x_d  = frame_end ? bus.i_Frog_X     : frog_x_q;
    frog_y_d  = frame_end ? bus.i_Frog_Y     : frog_y_q;
    car_x_d   = frame_end ? bus.i_Car_X      : car_x_q;
    car_y_d   = frame_end ? bus.i_Car_Y      : car_y_q;
    car_en_d  = frame_end ? bus.i_Car_Enable : car_en_q;
    car_col_d = frame_end ? bus.i_Car_Color  : car_col_q;

    visible  = (h_q < H_VIS) && (v_q < V_VIS);
    frog_hit = sprite_hit(h_q, v_q, frog_x_q, frog_y_q);
    car_hit  = '0;
    for (int i = 0; i < N_CARS; i++) begin
      car_hit[i] = car_en_q[i] && sprite_hit(h_q, v_q, car_x_q[10*i +: 10], car_y_q[10*i +: 10]);
    end

    vis_p1_d  = visible;
    hs_p1_d   = !((h_q >= HS_BEGIN) && (h_q < HS_END));
    vs_p1_d   = !((v_q >= VS_BEGIN) && (v_q < VS_END));
    frog_p1_d = frog_hit;
    car_p1_d  = car_hit;

    frame_start_d = (h_q == '0) && (v_q == '0);

    acc_d       = acc_q;
    mask_d      = mask_q;
    collision_d = 1'b0;
    if (visible && frog_hit) begin
      acc_d = acc_q | car_hit;
    end
    // First blanking line: report what the visible frame collected, then start afresh.
    if ((h_q == '0) && (v_q == V_VIS)) begin
      collision_d = |acc_q;
      if (|acc_q) begin
        mask_d = acc_q;
      end
      acc_d = '0;
    end
  end

  // Stage 1 -> 2: colour priority (frog, then lowest-index car) and sync alignment
  always_comb begin
    hsync_d = hs_p1_q;
    vsync_d = vs_p1_q;
    red_d   = '0;
    grn_d   = '0;
    blu_d   = '0;
    if (vis_p1_q) begin
      if (frog_p1_q) begin
        red_d = '1;
        grn_d = '1;
        blu_d = '1;
      end else begin
        for (int i = N_CARS - 1; i >= 0; i--) begin
          if (car_p1_q[i]) begin
            red_d = expand(car_col_q[3*i+2]);
            grn_d = expand(car_col_q[3*i+1]);
            blu_d = expand(car_col_q[3*i]);
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      h_q <= '0;            v_q <= '0;
      frog_x_q <= '0;       frog_y_q <= '0;
      car_x_q <= '0;        car_y_q <= '0;
      car_en_q <= '0;       car_col_q <= '0;
      vis_p1_q <= 1'b0;     hs_p1_q <= 1'b1;     vs_p1_q <= 1'b1;
      frog_p1_q <= 1'b0;    car_p1_q <= '0;
      hsync_q <= 1'b1;      vsync_q <= 1'b1;
      red_q <= '0;          grn_q <= '0;         blu_q <= '0;
      frame_start_q <= 1'b0;
      collision_q <= 1'b0;  acc_q <= '0;         mask_q <= '0;
    end else begin
      h_q <= h_d;           v_q <= v_d;
      frog_x_q <= frog_x_d; frog_y_q <= frog_y_d;
      car_x_q <= car_x_d;   car_y_q <= car_y_d;
      car_en_q <= car_en_d; car_col_q <= car_col_d;
      vis_p1_q <= vis_p1_d; hs_p1_q <= hs_p1_d;  vs_p1_q <= vs_p1_d;
      frog_p1_q <= frog_p1_d;
      car_p1_q <= car_p1_d;
      hsync_q <= hsync_d;   vsync_q <= vsync_d;
      red_q <= red_d;       grn_q <= grn_d;      blu_q <= blu_d;
      frame_start_q <= frame_start_d;
      collision_q <= collision_d;
      acc_q <= acc_d;       mask_q <= mask_d;
    end
  end

  assign bus.o_VGA_HSync      = hsync_q;
  assign bus.o_VGA_VSync      = vsync_q;
  assign bus.o_VGA_Red        = red_q;
  assign bus.o_VGA_Grn        = grn_q;
  assign bus.o_VGA_Blu        = blu_q;
  assign bus.o_Frame_Start    = frame_start_q;
  assign bus.o_Collision      = collision_q;
  assign bus.o_Collision_Mask = mask_q;
endmodule
